// File: rtl/alu_xbar_pe.sv
// rtl/alu_xbar_pe.sv - CGRA PE: 4x4 input crossbar, registered ALU, output mux, serial config chain (optional multiplier: ALU2_MUL_EN)
module alu_xbar_pe #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            config_en,
    input  logic            config_in,
    output logic            config_out,
    input  logic [size-1:0] in0,
    input  logic [size-1:0] in1,
    input  logic [size-1:0] mem_out,
    output logic [size-1:0] mem_in0,
    output logic [size-1:0] mem_in1,
    output logic [size-1:0] out0
);

    // Shift amount comes from b[4:0], further narrowed for datapaths under 32 bits
    localparam int SH_W = ($clog2(size) < 5) ? $clog2(size) : 5;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_EQ    = 4'd9;
    localparam logic [3:0] OP_LT    = 4'd10;
    localparam logic [3:0] OP_LTU   = 4'd11;
    localparam logic [3:0] OP_PASSA = 4'd12;
    localparam logic [3:0] OP_PASSB = 4'd13;
    localparam logic [3:0] OP_MIN   = 4'd14;

    logic [12:0]     cfg_q, cfg_d;
    logic [size-1:0] alu_q, alu_d;

    logic [3:0]      alu_op;
    logic            out_sel;
    logic [1:0]      xsel [4];
    logic [size-1:0] xsrc [4];
    logic [size-1:0] xout [4];
    logic [size-1:0] a, b;
    logic [SH_W-1:0] sh;

    assign alu_op  = cfg_q[3:0];
    assign out_sel = cfg_q[4];
    assign xsel[0] = cfg_q[6:5];
    assign xsel[1] = cfg_q[8:7];
    assign xsel[2] = cfg_q[10:9];
    assign xsel[3] = cfg_q[12:11];

    // X2 is the registered ALU result, so feedback through the crossbar never loops combinationally
    always_comb begin
        xsrc[0] = in0;
        xsrc[1] = in1;
        xsrc[2] = alu_q;
        xsrc[3] = mem_out;
        for (int k = 0; k < 4; k++) begin
            xout[k] = xsrc[xsel[k]];
        end
    end

    assign a          = xout[0];
    assign b          = xout[1];
    assign sh         = b[SH_W-1:0];
    assign mem_in0    = xout[2];
    assign mem_in1    = xout[3];
    assign out0       = out_sel ? mem_out : alu_q;
    assign config_out = cfg_q[12];

    always_comb begin
        cfg_d = config_en ? {cfg_q[11:0], config_in} : cfg_q;
    end

    always_comb begin
        alu_d = alu_q;
        case (alu_op)
            OP_ADD:   alu_d = a + b;
            OP_SUB:   alu_d = a - b;
`ifdef ALU2_MUL_EN
            OP_MUL:   alu_d = a * b;
`else
            OP_MUL:   alu_d = '0;
`endif
            OP_AND:   alu_d = a & b;
            OP_OR:    alu_d = a | b;
            OP_XOR:   alu_d = a ^ b;
            OP_SHL:   alu_d = a << sh;
            OP_SHR:   alu_d = a >> sh;
            OP_SRA:   alu_d = $unsigned($signed(a) >>> sh);
            OP_EQ:    alu_d = {{(size-1){1'b0}}, (a == b)};
            OP_LT:    alu_d = {{(size-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_LTU:   alu_d = {{(size-1){1'b0}}, (a < b)};
            OP_PASSA: alu_d = a;
            OP_PASSB: alu_d = b;
            OP_MIN:   alu_d = ($signed(a) < $signed(b)) ? a : b;
            default:  alu_d = alu_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q <= '0;
            alu_q <= '0;
        end else begin
            cfg_q <= cfg_d;
            alu_q <= alu_d;
        end
    end

endmodule

// File: tb/tb_alu_xbar_pe.sv
// tb/tb_alu_xbar_pe.sv - scoreboard bench for alu_xbar_pe with directed vectors
module tb_alu_xbar_pe;

    logic        clk = 1'b0;
    logic        reset;
    logic        config_en;
    logic        config_in;
    logic        config_out;
    logic [31:0] in0, in1, mem_out;
    logic [31:0] mem_in0, mem_in1, out0;

    alu_xbar_pe #(.size(32)) dut (
        .clk(clk), .reset(reset), .config_en(config_en), .config_in(config_in),
        .config_out(config_out), .in0(in0), .in1(in1), .mem_out(mem_out),
        .mem_in0(mem_in0), .mem_in1(mem_in1), .out0(out0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic expect_out(input string name, input int sel, input logic [31:0] v, input int lat);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        e.due  = cyc + lat;
        sb.push_back(e);
    endtask

    // Monitor: at each falling edge, retire every expectation due by now
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.sel)
                0:       got = out0;
                1:       got = {31'b0, config_out};
                2:       got = mem_in0;
                default: got = mem_in1;
            endcase
            n_cmp++;
            if (e.due < cyc) begin
                n_fail++;
                $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.name, e.due, cyc);
            end else if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, got, e.exp, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [12:0] v);
        config_en = 1'b1;
        for (int i = 12; i >= 0; i--) begin
            config_in = v[i];
            step();
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] exp;
    } op_vec_t;

    op_vec_t ops[13];

    initial begin
`ifdef ALU2_MUL_EN
        ops[0]  = '{4'd2,  32'hFFFFFFC0};
`else
        ops[0]  = '{4'd2,  32'h00000000};
`endif
        ops[1]  = '{4'd7,  32'h0FFFFFFF};
        ops[2]  = '{4'd8,  32'hFFFFFFFF};
        ops[3]  = '{4'd10, 32'h00000001};
        ops[4]  = '{4'd11, 32'h00000000};
        ops[5]  = '{4'd14, 32'hFFFFFFF0};
        ops[6]  = '{4'd1,  32'hFFFFFFEC};
        ops[7]  = '{4'd3,  32'h00000000};
        ops[8]  = '{4'd4,  32'hFFFFFFF4};
        ops[9]  = '{4'd5,  32'hFFFFFFF4};
        ops[10] = '{4'd6,  32'hFFFFFF00};
        ops[11] = '{4'd9,  32'h00000000};
        ops[12] = '{4'd13, 32'h00000004};

        // Reset with arbitrary inputs and an active shift request
        reset     = 1'b0;
        config_en = 1'b1;
        config_in = 1'b1;
        in0       = 32'h12345678;
        in1       = 32'h9ABC0000;
        mem_out   = 32'h00000055;
        step();
        expect_out("rst_out0", 0, 32'h0, 0);
        expect_out("rst_cfgout", 1, 32'h0, 0);
        expect_out("rst_mem_in0", 2, 32'h12345678, 0);
        expect_out("rst_mem_in1", 3, 32'h12345678, 0);
        step();
        expect_out("rst_cfgout_en", 1, 32'h0, 0);
        expect_out("rst_out0_2", 0, 32'h0, 0);
        step();

        // Release: alu computes in0+in0 = 0, config never shifted
        in0       = 32'h0;
        in1       = 32'h0000DEAD;
        mem_out   = 32'h0000BEEF;
        config_en = 1'b0;
        config_in = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            expect_out("post_rst_out0", 0, 32'h0, 0);
            expect_out("post_rst_cfgout", 1, 32'h0, 0);
        end
        step();

        // Accumulator: all sources zero while loading keeps alu_q at 0
        in1     = 32'h0;
        mem_out = 32'h0;
        load_cfg(13'h0C0);
        in1 = 32'd5;
        expect_out("acc1", 0, 32'd5, 1);
        expect_out("acc2", 0, 32'd10, 2);
        expect_out("acc3", 0, 32'd15, 3);
        step();
        step();
        step();
        step();

        // ADD wraps modulo 2^32
        in0 = 32'hFFFFFFFF;
        in1 = 32'd2;
        load_cfg(13'h080);
        expect_out("wrap_mem_in0", 2, 32'hFFFFFFFF, 0);
        expect_out("wrap_mem_in1", 3, 32'hFFFFFFFF, 0);
        expect_out("add_wrap", 0, 32'h1, 1);
        step();
        step();

        // Memory routing with out_sel=1
        load_cfg(13'h810);
        in0     = 32'h10;
        in1     = 32'h20;
        mem_out = 32'hAB;
        expect_out("mem_in0", 2, 32'h10, 0);
        expect_out("mem_in1", 3, 32'h20, 0);
        expect_out("mem_out0", 0, 32'hAB, 0);
        step();
        mem_out = 32'h5A;
        expect_out("mem_out0_b", 0, 32'h5A, 0);
        step();

        // Ops sweep on a=0xFFFFFFF0, b=4
        in0     = 32'hFFFFFFF0;
        in1     = 32'd4;
        mem_out = 32'h0;
        for (int i = 0; i < 13; i++) begin
            load_cfg(13'h080 | {9'b0, ops[i].op});
            expect_out($sformatf("op%0d", ops[i].op), 0, ops[i].exp, 1);
            step();
            step();
        end

        // HOLD: last loading edge computes mem_out>>0 = 0x80, then alu_q must stay put
        mem_out = 32'h80;
        load_cfg(13'h1FEF);
        expect_out("hold0", 0, 32'h80, 0);
        mem_out = 32'h1234;
        in0     = 32'h7;
        step();
        expect_out("hold1", 0, 32'h80, 0);
        step();
        expect_out("hold2", 0, 32'h80, 0);
        step();

        // Asynchronous reset mid-cycle clears alu_q immediately
        in0     = 32'h0;
        in1     = 32'h0;
        mem_out = 32'h0;
        reset   = 1'b0;
        expect_out("async_rst_out0", 0, 32'h0, 0);
        step();
        reset = 1'b1;
        step();

        // Config shift-through: 13 ones then 13 zeros, with a hold gap
        config_en = 1'b1;
        config_in = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            step();
            expect_out($sformatf("shift1_%0d", i), 1, (i == 13) ? 32'h1 : 32'h0, 0);
        end
        config_en = 1'b0;
        config_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("cfg_hold", 1, 32'h1, 0);
        end
        config_en = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            step();
            expect_out($sformatf("shift0_%0d", i), 1, (i < 13) ? 32'h1 : 32'h0, 0);
        end
        config_en = 1'b0;
        step();

        for (int i = 0; i < 50 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d checks left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
